led_scroll_ctrl: RTL and testbench
==================================

# led_scroll_ctrl

Scroll sequencer for the two 16-segment LED digits (`led_a` left, `led_b` right; segment patterns active-low, 16'hFFFF = all off). It holds a loadable message buffer of glyph patterns and, on a programmable tick, shifts the left digit from the right and loads the next glyph into the right digit. The host loads the buffer through a valid/ready write port, then issues start/stop. It sits between the message source logic and the LED pins and is clocked from the on-chip oscillator clock.

## Interface
- `TICK_DIV`, 4194304, clk cycles per scroll step (≥2); 2^22 gives ≈0.35 s at 12.09 MHz
- `DEPTH`, 32, buffer entries (power of 2, ≤64)
- `BLANK`, 16'hFFFF, pattern shifted in for flush/stop
- `clk`  in  1  oscillator clock; all logic on posedge
- `rst_n`  in  1  reset: synchronous, active-low
- `wr_valid`  in  1  glyph write request
- `wr_data`  in  16  glyph pattern
- `wr_ready`  out  1  = IDLE && len<DEPTH && !clr (combinational)
- `clr`  in  1  empty buffer (IDLE only)
- `start`  in  1  begin scroll (IDLE, len>0 only)
- `stop`  in  1  abort scroll
- `busy`  out  1  high in RUN/FLUSH
- `done`  out  1  one-cycle pulse at normal completion
- `len`  out  $clog2(DEPTH)+1  glyphs stored
- `led_a`  out  16  left digit pattern
- `led_b`  out  16  right digit pattern

## Operation
- Reset values: `led_a`=`led_b`=BLANK, `len`=0, `busy`=0, `done`=0, state IDLE, tick counter 0, `rd_idx` 0. Reset mid-scroll discards buffer length (len=0).
- States: IDLE, RUN, FLUSH.
- Write: `wr_valid && wr_ready` stores `wr_data` at `mem[len]`, `len`+1. At len==DEPTH `wr_ready`=0; writes dropped. `clr` in IDLE sets len=0 and wins over a same-cycle write. `clr` outside IDLE ignored.
- IDLE→RUN: `start && !stop && len>0`; clears tick counter and `rd_idx`. `start` with len==0, or while busy, ignored; no `done`.
- Tick: counter 0..TICK_DIV-1; tick when counter==TICK_DIV-1, then wraps to 0.
- RUN, on tick: `led_a`←`led_b`, `led_b`←`mem[rd_idx]`. If `rd_idx`==len-1 → FLUSH (flush count 0), else `rd_idx`+1.
- FLUSH, on tick: `led_a`←`led_b`, `led_b`←BLANK; after 2nd flush tick → IDLE, `done`=1 for that one cycle.
- `stop` in RUN/FLUSH: next edge `led_a`=`led_b`=BLANK, IDLE, no `done`. Buffer retained; next `start` replays from index 0. `stop` in IDLE ignored.
- Buffer contents never change outside IDLE.

## Timing
- `start` sampled at edge E0 → `busy` high after E0; first shift at edge E0+TICK_DIV.
- Shift k (k=1..) at edge E0+k·TICK_DIV.
- Non-loop run of N glyphs: N+2 shifts; `done` high in the cycle after edge E0+(N+2)·TICK_DIV, `busy` low at the same time; both digits BLANK.
- `len` updates the edge after an accepted write; `wr_ready` drops same cycle state leaves IDLE.
- `stop` latency: 1 edge.

## Configuration
- `SCROLL_LOOP_EN` defined: in RUN, after `rd_idx`==len-1 the next index is 0; FLUSH is never entered, `done` never pulses, scrolling continues until `stop` or reset.
- Undefined: single pass plus 2-tick flush, then `done`, as above.

## Test plan
(TICK_DIV=4, DEPTH=32)
- Reset with `rst_n`=0 mid-RUN → next edge `led_a`=`led_b`=16'hFFFF, `len`=0, `busy`=0, `wr_ready`=1.
- Write 16'h30FF,16'h00FF,16'hFFD5; start at E0 → E0+4: b=30FF; E0+8: a=30FF,b=00FF; E0+12: a=00FF,b=FFD5; E0+16: a=FFD5,b=FFFF; E0+20: both FFFF, `done` one cycle, `busy`=0.
- 33 back-to-back writes → 32 accepted, `len`=32, `wr_ready`=0 from after 32nd; entry 31 unchanged by 33rd.
- Stop at E0+9 on 3-glyph run → next edge both FFFF, `busy`=0, no `done`; restart → E+4: b=30FF.
- `start` with len=0 → stays IDLE; `clr`+`wr_valid` same cycle with len=5 → len=0.
- `SCROLL_LOOP_EN`, 2 glyphs A,B → b sequence A,B,A,B at E0+4/8/12/16; `done` never asserted; `stop` ends it.

Source files
------------

// File: rtl/led_scroll_ctrl.sv
// Two-digit 16-segment LED scroll sequencer with a loadable glyph buffer.
// Optional feature: define SCROLL_LOOP_EN to wrap the message endlessly instead of flushing.
module led_scroll_ctrl #(
    parameter int unsigned TICK_DIV = 4194304,
    parameter int unsigned DEPTH    = 32,
    parameter logic [15:0] BLANK    = 16'hFFFF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    input  logic [15:0]                wr_data,
    output logic                       wr_ready,
    input  logic                       clr,
    input  logic                       start,
    input  logic                       stop,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     len,
    output logic [15:0]                led_a,
    output logic [15:0]                led_b
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LEN_W = $clog2(DEPTH) + 1;
    localparam int CNT_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t            state;
    logic [CNT_W-1:0]  tick_cnt;
    logic [IDX_W-1:0]  rd_idx;
    logic              flush_cnt;
    logic [15:0]       mem [DEPTH];

    logic tick;
    logic last_idx;
    logic wr_fire;

    assign wr_ready = (state == IDLE) && (len < LEN_W'(DEPTH)) && !clr;
    assign wr_fire  = wr_valid && wr_ready;
    assign tick     = (tick_cnt == CNT_W'(TICK_DIV - 1));
    assign last_idx = (LEN_W'(rd_idx) == len - LEN_W'(1));

    // NOTE: the glyph array has no reset; len alone defines which entries are valid,
    // and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (rst_n && wr_fire)
            mem[len[IDX_W-1:0]] <= wr_data;
    end

    // NOTE: all state here uses non-blocking assignments so every register samples
    // pre-edge values; e.g. led_a <= led_b takes the old right digit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            len       <= '0;
            tick_cnt  <= '0;
            rd_idx    <= '0;
            flush_cnt <= 1'b0;
            led_a     <= BLANK;
            led_b     <= BLANK;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr)
                        len <= '0;
                    else if (wr_fire)
                        len <= len + LEN_W'(1);
                    if (start && !stop && len != '0) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        tick_cnt <= '0;
                        rd_idx   <= '0;
                    end
                end
                RUN, FLUSH: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        led_a <= BLANK;
                        led_b <= BLANK;
                    end else begin
                        tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
                        if (tick) begin
                            led_a <= led_b;
                            if (state == RUN) begin
                                led_b <= mem[rd_idx];
                                if (last_idx) begin
`ifdef SCROLL_LOOP_EN
                                    rd_idx <= '0;
`else
                                    state     <= FLUSH;
                                    flush_cnt <= 1'b0;
`endif
                                end else begin
                                    rd_idx <= rd_idx + IDX_W'(1);
                                end
                            end else begin
                                // Two blank shifts push the last glyph off the left digit.
                                led_b <= BLANK;
                                if (flush_cnt) begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end else begin
                                    flush_cnt <= 1'b1;
                                end
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_scroll_ctrl.sv
// Self-checking bench for led_scroll_ctrl (TICK_DIV=4, DEPTH=32); elapsed-time display model
// plus directed literal checks. Honours SCROLL_LOOP_EN when defined.
module tb_led_scroll_ctrl;

    localparam int          TD    = 4;
    localparam int          DEP   = 32;
    localparam logic [15:0] BLANK = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst_n, wr_valid, clr, start, stop;
    logic [15:0] wr_data;
    logic        wr_ready, busy, done;
    logic [5:0]  len;
    logic [15:0] led_a, led_b;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 0;

    led_scroll_ctrl #(.TICK_DIV(TD), .DEPTH(DEP), .BLANK(BLANK)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .clr(clr), .start(start), .stop(stop),
        .busy(busy), .done(done), .len(len), .led_a(led_a), .led_b(led_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Model: while scrolling, the display after k shifts is fully determined by the
    // message as a sequence: right digit = seq[k-1], left digit = seq[k-2].
    logic [15:0] m_buf [DEP];
    int          m_len, m_n, m_elapsed;
    bit          m_active, m_done;
    logic [15:0] m_a, m_b;

    function automatic logic [15:0] seq(input int i);
        if (i < 0) return BLANK;
`ifdef SCROLL_LOOP_EN
        return m_buf[i % m_n];
`else
        return (i < m_n) ? m_buf[i] : BLANK;
`endif
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_len = 0; m_active = 0; m_done = 0; m_a = BLANK; m_b = BLANK;
        end else begin
            m_done = 0;
            if (m_active) begin
                if (stop) begin
                    m_active = 0; m_a = BLANK; m_b = BLANK;
                end else begin
                    m_elapsed++;
                    if (m_elapsed % TD == 0) begin
                        int k;
                        k   = m_elapsed / TD;
                        m_b = seq(k - 1);
                        m_a = seq(k - 2);
`ifndef SCROLL_LOOP_EN
                        if (k == m_n + 2) begin
                            m_active = 0; m_done = 1;
                        end
`endif
                    end
                end
            end else begin
                bit go;
                go = start && !stop && m_len > 0;
                if (clr)
                    m_len = 0;
                else if (wr_valid && m_len < DEP) begin
                    m_buf[m_len] = wr_data;
                    m_len++;
                end
                if (go) begin
                    m_active = 1; m_elapsed = 0; m_n = m_len;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("cyc_busy",  32'(busy),  32'(m_active));
            check("cyc_done",  32'(done),  32'(m_done));
            check("cyc_len",   32'(len),   32'(m_len));
            check("cyc_led_a", 32'(led_a), 32'(m_a));
            check("cyc_led_b", 32'(led_b), 32'(m_b));
            check("cyc_ready", 32'(wr_ready), 32'(!m_active && m_len < DEP && !clr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic write(input logic [15:0] d);
        wr_valid = 1'b1; wr_data = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; clr = 1'b0; start = 1'b0; stop = 1'b0;
        steps(2);
        check_en = 1;
        check("rst_led_a", 32'(led_a), 32'hFFFF);
        check("rst_len",   32'(len),   32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_ready", 32'(wr_ready), 32'd1);
        rst_n = 1'b1;

        write(16'h30FF); write(16'h00FF); write(16'hFFD5);
        check("len3", 32'(len), 32'd3);

`ifndef SCROLL_LOOP_EN
        do_start();
        check("run_busy", 32'(busy), 32'd1);
        steps(4);
        check("e4_b",  32'(led_b), 32'h30FF);
        check("e4_a",  32'(led_a), 32'hFFFF);
        steps(4);
        check("e8_a",  32'(led_a), 32'h30FF);
        check("e8_b",  32'(led_b), 32'h00FF);
        steps(4);
        check("e12_a", 32'(led_a), 32'h00FF);
        check("e12_b", 32'(led_b), 32'hFFD5);
        steps(4);
        check("e16_a", 32'(led_a), 32'hFFD5);
        check("e16_b", 32'(led_b), 32'hFFFF);
        steps(4);
        check("e20_ab",   32'({led_a, led_b}), 32'hFFFF_FFFF);
        check("e20_done", 32'(done), 32'd1);
        check("e20_busy", 32'(busy), 32'd0);
        step();
        check("done_pulse", 32'(done), 32'd0);
`endif

        // Stop sampled at E0+9, then replay from index 0, then reset mid-run.
        do_start();
        steps(8);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_ab",   32'({led_a, led_b}), 32'hFFFF_FFFF);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_done", 32'(done), 32'd0);
        do_start();
        steps(4);
        check("replay_b", 32'(led_b), 32'h30FF);
        rst_n = 1'b0;
        step();
        check("mrst_ab",    32'({led_a, led_b}), 32'hFFFF_FFFF);
        check("mrst_len",   32'(len),  32'd0);
        check("mrst_busy",  32'(busy), 32'd0);
        check("mrst_ready", 32'(wr_ready), 32'd1);
        rst_n = 1'b1;

        do_start();
        check("empty_start", 32'(busy), 32'd0);

        for (int i = 0; i < 5; i++) write(16'hA000 + 16'(i));
        check("len5", 32'(len), 32'd5);
        clr = 1'b1; wr_valid = 1'b1; wr_data = 16'hBEEF;
        step();
        clr = 1'b0; wr_valid = 1'b0;
        check("clr_wins", 32'(len), 32'd0);

        wr_valid = 1'b1;
        for (int i = 0; i < 33; i++) begin
            wr_data = 16'h1000 + 16'(i);
            step();
            if (i == 31) begin
                check("full_len",   32'(len), 32'd32);
                check("full_ready", 32'(wr_ready), 32'd0);
            end
        end
        wr_valid = 1'b0;
        check("full_len2", 32'(len), 32'd32);
        do_start();
        steps(32 * TD);
        check("entry31", 32'(led_b), 32'h101F);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("full_stop", 32'(busy), 32'd0);

`ifdef SCROLL_LOOP_EN
        clr = 1'b1;
        step();
        clr = 1'b0;
        write(16'h1234); write(16'h5678);
        do_start();
        for (int j = 1; j <= 4; j++) begin
            steps(4);
            check("loop_b", 32'(led_b), (j % 2 == 1) ? 32'h1234 : 32'h5678);
        end
        steps(20);
        check("loop_busy", 32'(busy), 32'd1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("loop_stop", 32'(busy), 32'd0);
`endif

        steps(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
